pipeline_hazard_ctrl: RTL and testbench

//  Central stall/flush sequencer for the 5-stage MIPS pipeline; pairs with the forwarding unit.

---
 rtl/mips_pkg.sv | 23 ++
 rtl/wait_counter.sv | 29 ++
 rtl/pipeline_hazard_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared types for the MIPS pipeline hazard sequencer.
//   hz_state_t    : sequencer states (RUN, MD_WAIT, MEM_WAIT)
//   REG_ZERO      : architectural $zero, never a real dependency
//   load_use_hit  : load-use dependency test between the EX load and the ID instruction
package mips_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MD_WAIT  = 2'd1,
    MEM_WAIT = 2'd2
  } hz_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // A load into $zero produces nothing to wait for.
  function automatic logic load_use_hit(input logic       mem_read,
                                        input logic [4:0] ex_rt,
                                        input logic [4:0] id_rs,
                                        input logic [4:0] id_rt);
    return mem_read && (ex_rt != REG_ZERO) && ((ex_rt == id_rs) || (ex_rt == id_rt));
  endfunction

endpackage

// File: rtl/wait_counter.sv
// Shared wait counter for the hazard sequencer (MUL/DIV countdown and dmem wait count).
// Ports:
//   clk, rst_n   : clock, synchronous active-low reset (clears count)
//   load/load_val: load a start value (highest priority)
//   clr          : force to zero
//   dec / inc    : step down / up by one (dec wins over inc)
//   cnt          : current count, CNT_W bits
module wait_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             clr,
  input  logic             dec,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (!rst_n)     cnt <= '0;
    else if (load)  cnt <= load_val;
    else if (clr)   cnt <= '0;
    else if (dec)   cnt <= cnt - CNT_W'(1);
    else if (inc)   cnt <= cnt + CNT_W'(1);
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage MIPS pipeline. Handles the hazards the
// forwarding unit cannot: load-use, taken branch, jump, multi-cycle MUL/DIV,
// slow instruction fetch and slow data memory.
// Ports:
//   clk, rst_n                         : clock, synchronous active-low reset
//   IFID_Rs, IFID_Rt                   : sources of the instruction in ID
//   IDEX_MemRead, IDEX_Rt, IDEX_MulDiv : instruction in EX (load / its dest / MUL-DIV)
//   ID_jump, EX_branch_taken           : control transfers resolved in ID / EX
//   imem_ready, dmem_req, dmem_ready   : memory handshakes
//   PC_we, IFID_we, IDEX_we, EXMEM_we  : stage register enables (0 = hold)
//   IFID_flush..MEMWB_flush            : bubble insertion per stage register
//   md_start, md_done                  : MUL/DIV start / result capture pulses
//   mem_err                            : sticky dmem timeout flag
// Optional build: define HAZARD_PERF_EN to add 32-bit saturating cycle counters
//   perf_stall_ld, perf_stall_md, perf_stall_mem, perf_flush.
module pipeline_hazard_ctrl
  import mips_pkg::*;
#(
  parameter int MD_LATENCY  = 32,
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  IFID_Rs,
  input  logic [4:0]  IFID_Rt,
  input  logic        IDEX_MemRead,
  input  logic [4:0]  IDEX_Rt,
  input  logic        IDEX_MulDiv,
  input  logic        ID_jump,
  input  logic        EX_branch_taken,
  input  logic        imem_ready,
  input  logic        dmem_req,
  input  logic        dmem_ready,
  output logic        PC_we,
  output logic        IFID_we,
  output logic        IDEX_we,
  output logic        EXMEM_we,
  output logic        IFID_flush,
  output logic        IDEX_flush,
  output logic        EXMEM_flush,
  output logic        MEMWB_flush,
  output logic        md_start,
  output logic        md_done,
  output logic        mem_err
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] perf_stall_ld,
  output logic [31:0] perf_stall_md,
  output logic [31:0] perf_stall_mem,
  output logic [31:0] perf_flush
`endif
);

  localparam logic [CNT_W-1:0] MD_LOAD   = CNT_W'(MD_LATENCY - 1);
  localparam logic [CNT_W-1:0] MEM_LIMIT = CNT_W'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] MEM_LAST  = CNT_W'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  hz_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt;
  logic             cnt_load, cnt_clr, cnt_dec, cnt_inc, err_set;
  logic             dmem_stall, ld_hit, md_fin;

  assign dmem_stall = dmem_req && !dmem_ready;
  assign ld_hit     = load_use_hit(IDEX_MemRead, IDEX_Rt, IFID_Rs, IFID_Rt);
  // Last MUL/DIV cycle: the op leaves EX, so the still-set IDEX_MulDiv must not restart it.
  assign md_fin     = (state_q == MD_WAIT) && (cnt == CNT_ONE);

  wait_counter #(.CNT_W(CNT_W)) u_wait_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (MD_LOAD),
    .clr      (cnt_clr),
    .dec      (cnt_dec),
    .inc      (cnt_inc),
    .cnt      (cnt)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RUN;
      mem_err <= 1'b0;
    end else begin
      state_q <= state_d;
      if (err_set) mem_err <= 1'b1;
    end
  end

  always_comb begin
    PC_we       = 1'b1;
    IFID_we     = 1'b1;
    IDEX_we     = 1'b1;
    EXMEM_we    = 1'b1;
    IFID_flush  = 1'b0;
    IDEX_flush  = 1'b0;
    EXMEM_flush = 1'b0;
    MEMWB_flush = 1'b0;
    md_start    = 1'b0;
    md_done     = 1'b0;
    state_d     = state_q;
    cnt_load    = 1'b0;
    cnt_clr     = 1'b0;
    cnt_dec     = 1'b0;
    cnt_inc     = 1'b0;
    err_set     = 1'b0;

    if (!rst_n) begin
      // Pipeline runs freely while in reset; no pending md_done escapes.
    end else if (dmem_stall) begin
      PC_we       = 1'b0;
      IFID_we     = 1'b0;
      IDEX_we     = 1'b0;
      EXMEM_we    = 1'b0;
      MEMWB_flush = 1'b1;
      // During MD_WAIT the counter belongs to the MUL/DIV and is simply frozen.
      if (state_q != MD_WAIT) begin
        state_d = MEM_WAIT;
        if (cnt != MEM_LIMIT) cnt_inc = 1'b1;
        if (cnt == MEM_LAST)  err_set = 1'b1;
      end
    end else if ((state_q == MD_WAIT) && !md_fin) begin
      PC_we       = 1'b0;
      IFID_we     = 1'b0;
      IDEX_we     = 1'b0;
      EXMEM_flush = 1'b1;
      cnt_dec     = 1'b1;
    end else begin
      if (md_fin) begin
        md_done = 1'b1;
        cnt_dec = 1'b1;
        state_d = RUN;
      end else if (state_q == MEM_WAIT) begin
        cnt_clr = 1'b0 | 1'b1;
        state_d = RUN;
      end

      if (!md_fin && IDEX_MulDiv) begin
        md_start    = 1'b1;
        PC_we       = 1'b0;
        IFID_we     = 1'b0;
        IDEX_we     = 1'b0;
        EXMEM_flush = 1'b1;
        cnt_load    = 1'b1;
        state_d     = MD_WAIT;
      end else if (EX_branch_taken) begin
        IFID_flush = 1'b1;
        IDEX_flush = 1'b1;
      end else if (ld_hit) begin
        PC_we      = 1'b0;
        IFID_we    = 1'b0;
        IDEX_flush = 1'b1;
      end else if (ID_jump) begin
        IFID_flush = 1'b1;
      end else if (!imem_ready) begin
        PC_we      = 1'b0;
        IFID_flush = 1'b1;
      end
    end
  end

`ifdef HAZARD_PERF_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
  endfunction

  // Each cause is recognised from the output pattern it alone produces.
  logic ev_ld, ev_md, ev_mem, ev_flush;
  assign ev_mem   = MEMWB_flush;
  assign ev_md    = EXMEM_flush;
  assign ev_ld    = IDEX_flush && !PC_we;
  assign ev_flush = IFID_flush && PC_we;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_stall_ld  <= '0;
      perf_stall_md  <= '0;
      perf_stall_mem <= '0;
      perf_flush     <= '0;
    end else begin
      perf_stall_ld  <= sat_inc(perf_stall_ld,  ev_ld);
      perf_stall_md  <= sat_inc(perf_stall_md,  ev_md);
      perf_stall_mem <= sat_inc(perf_stall_mem, ev_mem);
      perf_flush     <= sat_inc(perf_flush,     ev_flush);
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl.
// dut_a: MD_LATENCY=4, MEM_TIMEOUT=255. dut_b: MD_LATENCY=16, MEM_TIMEOUT=3.
// Output vector order: {PC_we,IFID_we,IDEX_we,EXMEM_we,
//                       IFID_flush,IDEX_flush,EXMEM_flush,MEMWB_flush,md_start,md_done,mem_err}
module tb_pipeline_hazard_ctrl;

  localparam logic [10:0] NORM = 11'b1111_0000_000;
  localparam logic [10:0] LDU  = 11'b0011_0100_000;
  localparam logic [10:0] JMP  = 11'b1111_1000_000;
  localparam logic [10:0] IMEM = 11'b0111_1000_000;
  localparam logic [10:0] BR   = 11'b1111_1100_000;
  localparam logic [10:0] MDS  = 11'b0001_0010_100;
  localparam logic [10:0] MDH  = 11'b0001_0010_000;
  localparam logic [10:0] MDD  = 11'b1111_0000_010;
  localparam logic [10:0] MEMF = 11'b0000_0001_000;
  localparam logic [10:0] ERR  = 11'b0000_0000_001;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] IFID_Rs, IFID_Rt, IDEX_Rt;
  logic       IDEX_MemRead, IDEX_MulDiv, ID_jump, EX_branch_taken;
  logic       imem_ready, dmem_req, dmem_ready;

  logic a_pc, a_ifid, a_idex, a_exmem, a_fifid, a_fidex, a_fexmem, a_fmemwb, a_start, a_done, a_err;
  logic b_pc, b_ifid, b_idex, b_exmem, b_fifid, b_fidex, b_fexmem, b_fmemwb, b_start, b_done, b_err;
  logic [10:0] vec_a, vec_b;
  assign vec_a = {a_pc, a_ifid, a_idex, a_exmem, a_fifid, a_fidex, a_fexmem, a_fmemwb, a_start, a_done, a_err};
  assign vec_b = {b_pc, b_ifid, b_idex, b_exmem, b_fifid, b_fidex, b_fexmem, b_fmemwb, b_start, b_done, b_err};

`ifdef HAZARD_PERF_EN
  logic [31:0] a_pld, a_pmd, a_pmem, a_pfl, b_pld, b_pmd, b_pmem, b_pfl;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.MD_LATENCY(4), .MEM_TIMEOUT(255), .CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .IFID_Rs(IFID_Rs), .IFID_Rt(IFID_Rt),
    .IDEX_MemRead(IDEX_MemRead), .IDEX_Rt(IDEX_Rt), .IDEX_MulDiv(IDEX_MulDiv),
    .ID_jump(ID_jump), .EX_branch_taken(EX_branch_taken), .imem_ready(imem_ready),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .PC_we(a_pc), .IFID_we(a_ifid), .IDEX_we(a_idex), .EXMEM_we(a_exmem),
    .IFID_flush(a_fifid), .IDEX_flush(a_fidex), .EXMEM_flush(a_fexmem), .MEMWB_flush(a_fmemwb),
    .md_start(a_start), .md_done(a_done), .mem_err(a_err)
`ifdef HAZARD_PERF_EN
    , .perf_stall_ld(a_pld), .perf_stall_md(a_pmd), .perf_stall_mem(a_pmem), .perf_flush(a_pfl)
`endif
  );

  pipeline_hazard_ctrl #(.MD_LATENCY(16), .MEM_TIMEOUT(3), .CNT_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .IFID_Rs(IFID_Rs), .IFID_Rt(IFID_Rt),
    .IDEX_MemRead(IDEX_MemRead), .IDEX_Rt(IDEX_Rt), .IDEX_MulDiv(IDEX_MulDiv),
    .ID_jump(ID_jump), .EX_branch_taken(EX_branch_taken), .imem_ready(imem_ready),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .PC_we(b_pc), .IFID_we(b_ifid), .IDEX_we(b_idex), .EXMEM_we(b_exmem),
    .IFID_flush(b_fifid), .IDEX_flush(b_fidex), .EXMEM_flush(b_fexmem), .MEMWB_flush(b_fmemwb),
    .md_start(b_start), .md_done(b_done), .mem_err(b_err)
`ifdef HAZARD_PERF_EN
    , .perf_stall_ld(b_pld), .perf_stall_md(b_pmd), .perf_stall_mem(b_pmem), .perf_flush(b_pfl)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    IFID_Rs = 5'd0; IFID_Rt = 5'd0; IDEX_Rt = 5'd0;
    IDEX_MemRead = 1'b0; IDEX_MulDiv = 1'b0; ID_jump = 1'b0; EX_branch_taken = 1'b0;
    imem_ready = 1'b1; dmem_req = 1'b0; dmem_ready = 1'b1;
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    tick(); tick();
    #1 chk("rst_a", 32'(vec_a), 32'(NORM));
    chk("rst_b", 32'(vec_b), 32'(NORM));
    rst_n = 1'b1;
    tick();

    #1 chk("idle", 32'(vec_a), 32'(NORM));
    tick();

    // load-use on Rs, then the bubble cycle
    IDEX_MemRead = 1'b1; IDEX_Rt = 5'd2; IFID_Rs = 5'd2; IFID_Rt = 5'd7;
    #1 chk("ld_rs", 32'(vec_a), 32'(LDU));
    tick();
    idle();
    #1 chk("ld_bubble", 32'(vec_a), 32'(NORM));
    tick();
    IDEX_MemRead = 1'b1; IDEX_Rt = 5'd2; IFID_Rs = 5'd5; IFID_Rt = 5'd2;
    #1 chk("ld_rt", 32'(vec_a), 32'(LDU));
    tick();
    IDEX_Rt = 5'd0; IFID_Rs = 5'd0; IFID_Rt = 5'd0;
    #1 chk("ld_r0", 32'(vec_a), 32'(NORM));
    tick();
    IDEX_Rt = 5'd3; IFID_Rs = 5'd4; IFID_Rt = 5'd5;
    #1 chk("ld_miss", 32'(vec_a), 32'(NORM));
    tick();

    idle(); ID_jump = 1'b1;
    #1 chk("jump", 32'(vec_a), 32'(JMP));
    tick();
    idle(); imem_ready = 1'b0;
    #1 chk("imem", 32'(vec_a), 32'(IMEM));
    tick();
    ID_jump = 1'b1;
    #1 chk("jmp_imem", 32'(vec_a), 32'(JMP));
    tick();
    idle(); IDEX_MemRead = 1'b1; IDEX_Rt = 5'd2; IFID_Rs = 5'd2; ID_jump = 1'b1;
    #1 chk("ld_jmp", 32'(vec_a), 32'(LDU));
    tick();
    EX_branch_taken = 1'b1;
    #1 chk("br_ld", 32'(vec_a), 32'(BR));
    tick();
    idle(); EX_branch_taken = 1'b1; imem_ready = 1'b0;
    #1 chk("br_imem", 32'(vec_a), 32'(BR));
    tick();
    idle();
`ifdef HAZARD_PERF_EN
    #1 chk("perf_ld", a_pld, 32'd3);
    chk("perf_flush", a_pfl, 32'd4);
`endif

    // MUL/DIV, latency 4 on dut_a; dut_b (latency 16) keeps waiting
    IDEX_MulDiv = 1'b1;
    #1 chk("md_T0", 32'(vec_a), 32'(MDS));
    chk("md_b_T0", 32'(vec_b), 32'(MDS));
    tick();
    #1 chk("md_T1", 32'(vec_a), 32'(MDH));
    tick();
    #1 chk("md_T2", 32'(vec_a), 32'(MDH));
    tick();
    #1 chk("md_T3", 32'(vec_a), 32'(MDD));
    tick();
    IDEX_MulDiv = 1'b0;
    #1 chk("md_T4", 32'(vec_a), 32'(NORM));
    tick();
    tick();
    #1 chk("md_b_cnt10", 32'(vec_b), 32'(MDH));
    rst_n = 1'b0;
    #1 chk("md_b_rst", 32'(vec_b), 32'(NORM));
    tick();
    rst_n = 1'b1;
    #1 chk("md_b_after_rst", 32'(vec_b), 32'(NORM));
    chk("md_a_after_rst", 32'(vec_a), 32'(NORM));
`ifdef HAZARD_PERF_EN
    chk("perf_rst_ld", b_pld, 32'd0);
    chk("perf_rst_md", b_pmd, 32'd0);
    chk("perf_rst_mem", b_pmem, 32'd0);
    chk("perf_rst_fl", b_pfl, 32'd0);
`endif
    tick();

    // MUL/DIV interrupted by a dmem stall: countdown freezes
    IDEX_MulDiv = 1'b1;
    #1 chk("mdm_T0", 32'(vec_a), 32'(MDS));
    tick();
    #1 chk("mdm_T1", 32'(vec_a), 32'(MDH));
    tick();
    dmem_req = 1'b1; dmem_ready = 1'b0;
    #1 chk("mdm_st1", 32'(vec_a), 32'(MEMF));
    tick();
    #1 chk("mdm_st2", 32'(vec_a), 32'(MEMF));
    tick();
    dmem_ready = 1'b1;
    #1 chk("mdm_T2", 32'(vec_a), 32'(MDH));
    tick();
    dmem_req = 1'b0;
    #1 chk("mdm_T3", 32'(vec_a), 32'(MDD));
    tick();
    IDEX_MulDiv = 1'b0;
    #1 chk("mdm_T4", 32'(vec_a), 32'(NORM));
    tick();
    reset_pulse();

    // dmem wait: 5 cycles; dut_b times out after 3
    dmem_req = 1'b1; dmem_ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      #1 chk($sformatf("mem_a_%0d", k), 32'(vec_a), 32'(MEMF));
      chk($sformatf("mem_b_%0d", k), 32'(vec_b), (k >= 4) ? 32'(MEMF | ERR) : 32'(MEMF));
      tick();
    end
    dmem_ready = 1'b1;
    #1 chk("mem_rel_a", 32'(vec_a), 32'(NORM));
    chk("mem_rel_b", 32'(vec_b), 32'(NORM | ERR));
`ifdef HAZARD_PERF_EN
    chk("perf_mem", a_pmem, 32'd5);
`endif
    tick();
    idle(); EX_branch_taken = 1'b1;
    #1 chk("err_sticky_br", 32'(vec_b), 32'(BR | ERR));
    tick();
    idle();
    #1 chk("err_sticky", 32'(b_err), 32'd1);
    reset_pulse();
    #1 chk("err_cleared", 32'(vec_b), 32'(NORM));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
